// File: rtl/noc_pkg.sv
// Shared constants and types for the NoC output-port allocator.
package noc_pkg;
  localparam int NUM_PORTS  = 5;
  localparam int DATA_WIDTH = 32;
  localparam int IDX_WIDTH  = 3;

  localparam int PORT_N     = 4;
  localparam int PORT_E     = 3;
  localparam int PORT_S     = 2;
  localparam int PORT_W     = 1;
  localparam int PORT_LOCAL = 0;

  typedef enum logic {IDLE, LOCKED} arb_state_t;
endpackage

// File: rtl/noc_port_arbiter_if.sv
// Request side (five inputs) and link side of one router output port.
interface noc_port_arbiter_if #(
  parameter int NUM_PORTS  = 5,
  parameter int DATA_WIDTH = 32,
  parameter int IDX_WIDTH  = 3
);
  logic [NUM_PORTS-1:0][DATA_WIDTH-1:0] in_data;
  logic [NUM_PORTS-1:0]                 in_valid;
  logic [NUM_PORTS-1:0]                 in_last;
  logic [NUM_PORTS-1:0]                 in_ready;
  logic [DATA_WIDTH-1:0]                out_data;
  logic                                 out_valid;
  logic                                 out_last;
  logic                                 out_ready;
  logic [IDX_WIDTH-1:0]                 grant_idx;
  logic                                 busy;

  modport master (
    output in_data, in_valid, in_last, out_ready,
    input  in_ready, out_data, out_valid, out_last, grant_idx, busy
  );

  modport slave (
    input  in_data, in_valid, in_last, out_ready,
    output in_ready, out_data, out_valid, out_last, grant_idx, busy
  );
endinterface

// File: rtl/noc_port_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first requester at or above ptr, wrapping.
module rr_arbiter #(
  parameter int NUM_PORTS = 5,
  parameter int IDX_WIDTH = 3
) (
  input  logic [NUM_PORTS-1:0] req,
  input  logic [IDX_WIDTH-1:0] ptr,
  output logic [NUM_PORTS-1:0] gnt,
  output logic [IDX_WIDTH-1:0] idx,
  output logic                 any_req
);
  always_comb begin
    int   pos;
    logic found;
    gnt     = '0;
    idx     = '0;
    any_req = |req;
    found   = 1'b0;
    pos     = 0;
    for (int off = 0; off < NUM_PORTS; off++) begin
      pos = (int'(ptr) + off) % NUM_PORTS;
      if (!found && req[pos]) begin
        found    = 1'b1;
        gnt[pos] = 1'b1;
        idx      = IDX_WIDTH'(pos);
      end
    end
  end
endmodule

// File: rtl/noc_port_arbiter.sv
// Wormhole output-port allocator: round-robin head arbitration, grant held to
// the tail, one-entry registered output stage with valid/ready.
module noc_port_arbiter
  import noc_pkg::*;
#(
  parameter int DATA_WIDTH = noc_pkg::DATA_WIDTH,
  parameter int NUM_PORTS  = noc_pkg::NUM_PORTS,
  parameter int IDX_WIDTH  = noc_pkg::IDX_WIDTH
) (
  input  logic clk,
  input  logic rst,
  noc_port_arbiter_if.slave bus
);
  arb_state_t state, state_nxt;

  logic [IDX_WIDTH-1:0]  rr_ptr, owner, sel, win_idx, ptr_inc, grant_q;
  logic [NUM_PORTS-1:0]  win_gnt, ready_vec;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  any_req, can_accept, req_ok, accept, sel_last;
  logic                  valid_q, last_q;

  rr_arbiter #(.NUM_PORTS(NUM_PORTS), .IDX_WIDTH(IDX_WIDTH)) u_rr (
    .req     (bus.in_valid),
    .ptr     (rr_ptr),
    .gnt     (win_gnt),
    .idx     (win_idx),
    .any_req (any_req)
  );

  assign can_accept = !valid_q || bus.out_ready;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept && !sel_last) state_nxt = LOCKED;
      LOCKED:  if (accept &&  sel_last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // While locked, only the owner is looked at; other valid inputs are ignored.
  always_comb begin
    sel       = owner;
    req_ok    = bus.in_valid[owner];
    ready_vec = NUM_PORTS'(1) << owner;
    if (state == IDLE) begin
      sel       = win_idx;
      req_ok    = any_req;
      ready_vec = win_gnt;
    end
    accept      = !rst && can_accept && req_ok;
    bus.in_ready = accept ? ready_vec : '0;
  end

  assign sel_last = bus.in_last[sel];
  assign ptr_inc  = (sel == IDX_WIDTH'(NUM_PORTS-1)) ? '0 : sel + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr  <= '0;
      owner   <= '0;
      grant_q <= '0;
      data_q  <= '0;
      last_q  <= 1'b0;
      valid_q <= 1'b0;
    end else if (accept) begin
      owner   <= sel;
      grant_q <= sel;
      data_q  <= bus.in_data[sel];
      last_q  <= sel_last;
      valid_q <= 1'b1;
      if (sel_last) rr_ptr <= ptr_inc;
    end else if (bus.out_ready) begin
      valid_q <= 1'b0;
    end
  end

  assign bus.out_data  = data_q;
  assign bus.out_valid = valid_q;
  assign bus.out_last  = last_q;
  assign bus.grant_idx = grant_q;
  assign bus.busy      = (state == LOCKED);
endmodule
